app_src_feeder: RTL

//  Credit-based elastic buffer that feeds the application injector's source port
//  (src_eoa / src_rx / src_credit / src_data) from a host/testbench valid-ready stream.

---
 rtl/app_src_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/app_src_feeder.sv
// ============================================================================
// Module   : app_src_feeder
// Purpose  : Credit-based FWFT elastic buffer feeding the injector source port
//            from a valid-ready host stream, with end-of-applications sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module app_src_feeder #(
    parameter int DEPTH     = 16,
    parameter int FLIT_SIZE = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       host_valid_i,
    output logic                       host_ready_o,
    input  logic [FLIT_SIZE-1:0]       host_data_i,
    input  logic                       host_eoa_i,
    output logic                       src_eoa_o,
    output logic                       src_rx_o,
    input  logic                       src_credit_i,
    output logic [FLIT_SIZE-1:0]       src_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [31:0]                words_sent_o
);

    localparam int                 c_AW      = $clog2(DEPTH);
    localparam logic [c_AW-1:0]    c_PTR_ONE = c_AW'(1);
    localparam logic [c_AW:0]      c_LVL_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW:0]      c_FULL    = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [FLIT_SIZE-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_AW:0]          r_level;
    logic [31:0]            r_words_sent;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == c_FULL);
    assign w_empty = (r_level == '0);

    // Ready and valid are functions of registered state only, so no
    // combinational path exists from the host side to the source side.
    assign host_ready_o = (r_state == ST_RUN) && !w_full;
    assign src_rx_o     = !w_empty;
    assign src_data_o   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign src_eoa_o    = (r_state == ST_DONE);
    assign level_o      = r_level;
    assign words_sent_o = r_words_sent;

    assign w_push = host_valid_i && host_ready_o;
    assign w_pop  = src_rx_o && src_credit_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= host_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_words_sent <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                if (r_words_sent != 32'hFFFF_FFFF) begin
                    r_words_sent <= r_words_sent + 32'd1;
                end
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - c_LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (host_eoa_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish once the last buffered word leaves this cycle.
                if (w_empty || (r_level == c_LVL_ONE && w_pop)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

endmodule

`default_nettype wire
